// File: rtl/adj_key_conditioner.sv
// rtl/adj_key_conditioner.sv - hour/minute adjust key synchroniser, 1 ms-tick debouncer and pulse generator
// Auto-repeat while a key is held is built only when ADJ_AUTOREPEAT_EN is defined.
module adj_key_conditioner #(
  parameter int TICK_DIV        = 50000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic CP50,
  input  logic nCR,
  input  logic AdjH,
  input  logic AdjM,
  output logic AdjHLevel,
  output logic AdjMLevel,
  output logic AdjHPulse,
  output logic AdjMPulse
);
  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]    DEB_N      = 10'(DEBOUNCE_MS);
`ifdef ADJ_AUTOREPEAT_EN
  localparam logic [9:0]    DELAY_N    = 10'(REPEAT_DELAY_MS);
  localparam logic [9:0]    RATE_N     = 10'(REPEAT_RATE_MS);
`endif

  if (TICK_DIV < 2 || DEBOUNCE_MS < 1 || DEBOUNCE_MS > 1023 ||
      REPEAT_DELAY_MS < 1 || REPEAT_DELAY_MS > 1023 ||
      REPEAT_RATE_MS < 1 || REPEAT_RATE_MS > 1023) begin : g_bad_params
    $error("adj_key_conditioner: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD_DELAY,
    ST_HELD_REPEAT,
    ST_DEB_RELEASE
  } state_t;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic          w_tick;
  logic [1:0]    w_level;
  logic [1:0]    w_pulse;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge CP50 or negedge nCR) begin
    if (!nCR) begin
      r_presc <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_sync1 <= {AdjM, AdjH};
      r_sync2 <= r_sync1;
    end
  end

  // Channel 0 is the hour key, channel 1 the minute key; s is checked before tick everywhere.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    state_t     r_state;
    logic [9:0] r_cnt;
    logic       r_level;
    logic       r_pulse;
    logic       w_s;
    logic [9:0] w_cnt_nxt;

    assign w_s       = r_sync2[g];
    assign w_cnt_nxt = r_cnt + 10'd1;
    assign w_level[g] = r_level;
    assign w_pulse[g] = r_pulse;

    always_ff @(posedge CP50 or negedge nCR) begin
      if (!nCR) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_s) begin
              r_state <= ST_DEB_PRESS;
              r_cnt   <= '0;
            end
          end
          ST_DEB_PRESS: begin
            if (!w_s) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (w_cnt_nxt == DEB_N) begin
                r_state <= ST_HELD_DELAY;
                r_cnt   <= '0;
                r_level <= 1'b1;
                r_pulse <= 1'b1;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end
          end
          ST_HELD_DELAY: begin
            if (!w_s) begin
              r_state <= ST_DEB_RELEASE;
              r_cnt   <= '0;
            end
`ifdef ADJ_AUTOREPEAT_EN
            else if (w_tick) begin
              if (w_cnt_nxt == DELAY_N) begin
                r_state <= ST_HELD_REPEAT;
                r_cnt   <= '0;
                r_pulse <= 1'b1;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end
`endif
          end
`ifdef ADJ_AUTOREPEAT_EN
          ST_HELD_REPEAT: begin
            if (!w_s) begin
              r_state <= ST_DEB_RELEASE;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (w_cnt_nxt == RATE_N) begin
                r_cnt   <= '0;
                r_pulse <= 1'b1;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end
          end
`endif
          ST_DEB_RELEASE: begin
            if (w_s) begin
              r_state <= ST_HELD_DELAY;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (w_cnt_nxt == DEB_N) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end
        endcase
      end
    end
  end

  assign AdjHLevel = w_level[0];
  assign AdjMLevel = w_level[1];
  assign AdjHPulse = w_pulse[0];
  assign AdjMPulse = w_pulse[1];

endmodule

// File: doc/adj_key_conditioner.md
# adj_key_conditioner

Conditions the two raw clock-adjust push-buttons (hour, minute) before they reach the clock core. Each key is synchronised to CP50, debounced on a shared 1 ms tick, and turned into a level plus single-cycle adjust pulses, with optional auto-repeat while held. The outputs drive the hour/minute adjust increments of the main clock datapath.

## Interface
- TICK_DIV, 50000: CP50 cycles per 1 ms tick; ≥2.
- DEBOUNCE_MS, 20: stable ticks required to accept a press or release; 1..1023.
- REPEAT_DELAY_MS, 500: ticks from accepted press to first repeat pulse; 1..1023.
- REPEAT_RATE_MS, 100: ticks between subsequent repeat pulses; 1..1023.

- CP50  in  1  system clock, 50 MHz, rising edge.
- nCR  in  1  asynchronous active-low reset.
- AdjH  in  1  raw hour-adjust key, active high, asynchronous.
- AdjM  in  1  raw minute-adjust key, active high, asynchronous.
- AdjHLevel  out  1  debounced hour key state.
- AdjMLevel  out  1  debounced minute key state.
- AdjHPulse  out  1  one-cycle hour increment request.
- AdjMPulse  out  1  one-cycle minute increment request.

## Operation
- Reset (nCR low): synchronisers, prescaler, counters cleared; both channels in IDLE; all four outputs 0. Takes effect immediately, mid-press included; after release, a still-held key must be re-debounced from IDLE.
- Input path: two-flop synchroniser per key; FSM sees the second flop (call it s).
- Prescaler: counts 0..TICK_DIV-1, wraps; tick asserted one cycle when count = TICK_DIV-1. Shared by both channels.
- Per-channel FSM, 10-bit tick counter cnt, cleared on every state entry; cnt increments only on tick:
  - IDLE: s=1 -> DEB_PRESS.
  - DEB_PRESS: s=0 -> IDLE (no pulse). tick and cnt+1 = DEBOUNCE_MS -> HELD_DELAY; Level<=1; Pulse<=1.
  - HELD_DELAY: s=0 -> DEB_RELEASE. tick and cnt+1 = REPEAT_DELAY_MS -> HELD_REPEAT; Pulse<=1.
  - HELD_REPEAT: s=0 -> DEB_RELEASE. tick and cnt+1 = REPEAT_RATE_MS -> Pulse<=1, cnt<=0, stay.
  - DEB_RELEASE: s=1 -> HELD_DELAY (no pulse, Level stays 1). tick and cnt+1 = DEBOUNCE_MS -> IDLE; Level<=0.
- s is checked before tick: a bounce in the tick cycle aborts the transition.
- Pulse is registered, high exactly one cycle, never on two consecutive cycles.
- Channels independent: simultaneous presses give independent, possibly same-cycle, pulses. Arbitration belongs to the consumer.

## Timing
- Input to s: 2 cycles.
- Press accept: DEBOUNCE_MS ticks of continuous s=1, i.e. between (DEBOUNCE_MS-1)·TICK_DIV+1 and DEBOUNCE_MS·TICK_DIV cycles after s rises, plus 1 cycle for registered Level/Pulse.
- First repeat REPEAT_DELAY_MS ticks after accept; later repeats every REPEAT_RATE_MS ticks, exactly REPEAT_RATE_MS·TICK_DIV cycles apart.
- Release: Level falls DEBOUNCE_MS ticks after s stays 0; no pulse on release.

## Configuration
- ADJ_AUTOREPEAT_EN defined: behaviour as above.
- Undefined: HELD_DELAY and HELD_REPEAT merge into one HELD state, which only exits to DEB_RELEASE on s=0. Exactly one Pulse per accepted press. REPEAT_* parameters ignored.

## Test plan
Common settings: TICK_DIV=4, DEBOUNCE_MS=3, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=4, ADJ_AUTOREPEAT_EN defined.
- Reset: hold nCR=0 with AdjH=AdjM=1 -> all outputs 0; after nCR=1, AdjHPulse first appears ≥3 ticks later.
- Bounce reject: AdjH high 9 cycles, low 2, repeated 10× -> no AdjHPulse, AdjHLevel stays 0.
- Clean press/release: AdjH high 6 ticks then low -> exactly 1 AdjHPulse; AdjHLevel high, then falls 3 ticks after s falls.
- Auto-repeat: AdjM held through tick 33 after s rise -> 7 AdjMPulses (ticks 3, 13, 17, 21, 25, 29, 33), repeat spacing 16 cycles.
- Simultaneous: AdjH and AdjM rise on the same cycle -> both pulses in the same cycle; no interaction.
- Mid-operation reset, and ADJ_AUTOREPEAT_EN undefined: nCR pulse during HELD_REPEAT -> outputs 0 at once. Rerun the auto-repeat case with the macro undefined -> exactly 1 AdjMPulse.
